if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch (IF) stage of the 5-stage RV32I pipeline. It produces InstrF/PCF/PCPlus4F for the
//   IF/ID register in decode. It owns the PC, issues requests to a variable-latency instruction memory
//   over a valid/ready request + valid response interface, and buffers returned instructions in a
//   2-entry FIFO. It obeys the hazard unit's stall (en) and the execute stage's redirect (PCSrcE).
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC fetched first after reset
//   NOP_INSTR  32'h0000_0013  addi x0,x0,0; driven on InstrF when no valid instruction is available
//   BUF_DEPTH  2              fetch FIFO entries (power of 2, >=2)
// PORTS
//   clk             in   1   clock
//   reset           in   1   asynchronous, active-high reset
//   en              in   1   decode accepts (IF/ID enable, i.e. ~StallF); pops FIFO head when fetch_valid
//   PCSrcE          in   1   redirect request from EX (taken branch / jump / jalr)
//   PCTargetE       in   32  redirect target
//   imem_req_valid  out  1   fetch request valid
//   imem_req_ready  in   1   memory accepts request
//   imem_req_addr   out  32  word address of request (bits[1:0]=00)
//   imem_rsp_valid  in   1   response valid (>=1 cycle after acceptance, in order, never back-pressured)
//   imem_rsp_data   in   32  returned instruction
//   fetch_valid     out  1   InstrF/PCF/PCPlus4F hold a real instruction
//   InstrF          out  32  FIFO head instr, else NOP_INSTR
//   PCF             out  32  FIFO head PC, else 0
//   PCPlus4F        out  32  PCF+4 mod 2^32
// BEHAVIOUR
//   - Reset (async): fetch_pc=RESET_PC, FIFO empty, state=RUN; imem_req_valid=0 in the reset cycle,
//     fetch_valid=0, InstrF=NOP_INSTR, PCF=0, PCPlus4F=4.
//   - Exactly one request is outstanding at a time. Credit check: fifo_count + outstanding < BUF_DEPTH.
//   - FSM states:
//       RUN      - no outstanding request.
//                  Drive req_valid when the credit check passes; addr = fetch_pc.
//                  On req_valid & req_ready: fetch_pc += 4, go to WAIT.
//       WAIT     - one request outstanding.
//                  On rsp_valid: push {pc_of_req, rsp_data}.
//                  In the same cycle, req_valid may assert for fetch_pc (credit counts the pushed entry);
//                  if that request is accepted, stay in WAIT, else go to RUN.
//       DRAIN    - outstanding response belongs to a squashed path.
//                  On rsp_valid: discard it and go to RUN.
//                  req_valid=0 while in DRAIN.
//   - Pop: the FIFO head is removed when en & fetch_valid. Push and pop may occur in the same cycle;
//     the count is unchanged.
//   - A push is visible on the outputs the next cycle. Minimum latency: accepted at N, rsp at N+1,
//     fetch_valid at N+2. Sustained throughput is 1 instr/cycle with 1-cycle memory and en=1.
//   - Redirect (PCSrcE=1) has priority over all other events, including en=0 and a simultaneous
//     rsp_valid:
//       * FIFO flushed; fetch_valid=0 next cycle.
//       * fetch_pc <= {PCTargetE[31:2],2'b00} (misaligned low bits dropped).
//       * If a request is outstanding, or accepted in this same cycle, go to DRAIN; else go to RUN.
//       * A response arriving in the redirect cycle is discarded.
//       * req_valid is forced to 0 in the redirect cycle.
//   - en=0: outputs hold (no pop). Fetching continues until the FIFO is full, then stalls.
//   - PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. PCPlus4F wraps the same way.
//   - Reset mid-operation: the outstanding request is forgotten. Memory is reset on the same reset
//     and issues no stale response.
//   - imem_req_addr/valid stay stable while valid & ~ready, unless a redirect occurs.
// STRUCTURE
//   - fetch_pkg: fetch_state_t enum {RUN,WAIT,DRAIN}; fetch_entry_t struct {pc[31:0], instr[31:0]};
//     NOP_INSTR and RESET_PC defaults.
//   - Sub-module fetch_fifo: BUF_DEPTH x fetch_entry_t, synchronous flush, push/pop/full/empty/count.
//   - Top level: FSM, PC register, credit logic and output mux.
// TESTING
//   1. Reset, 1-cycle memory, en=1:
//      -> req addrs 0,4,8,... on consecutive cycles; fetch_valid first at cycle 2 with PCF=0, then
//         one instr/cycle.
//   2. en=0 for 5 cycles, memory always ready:
//      -> exactly 2 entries buffered, req_valid then 0; outputs hold; en=1 resumes in order with no
//         loss or duplication.
//   3. 3-cycle response latency, redirect PCSrcE=1, PCTargetE=32'h100 while in WAIT:
//      -> late response dropped, next req addr=32'h100, first fetch_valid has PCF=32'h100.
//   4. Redirect in the same cycle as rsp_valid and en=0:
//      -> FIFO empty next cycle, response not delivered, fetch resumes at the target.
//   5. RESET_PC=32'hFFFF_FFF8:
//      -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4F=0 for PCF=FFFF_FFFC.
//   6. reset asserted while in WAIT:
//      -> outputs reset immediately (NOP, fetch_valid=0); first req after release at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Imported by the fetch FIFO and the fetch stage top level.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int          BUF_DEPTH_DEF = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries.
// Synchronous flush empties it; push and pop may coincide.
import fetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = BUF_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    // Status flags and qualified push/pop strobes
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd_ptr];
    end

    // Pointers and occupancy; flush drops everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage, written only on a real push
    always_ff @(posedge clk) begin
        if (do_push & ~flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, one-outstanding imem requests,
// fetch buffer, stall and EX redirect handling.
import fetch_pkg::*;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          push;
    logic          pop;
    logic          req_ok;
    logic          accept;
    logic [CW:0]   credit;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (PCSrcE),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    // Credit check counts this cycle's push and pop so 1-cycle memory streams
    always_comb begin
        pop        = en & ~empty & ~PCSrcE;
        push       = imem_rsp_valid & (state == WAIT) & ~PCSrcE;
        push_entry = '{pc: req_pc, instr: imem_rsp_data};
        credit     = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
        req_ok     = 1'b0;
        unique case (state)
            RUN:     req_ok = 1'b1;
            WAIT:    req_ok = imem_rsp_valid;
            DRAIN:   req_ok = 1'b0;
            default: req_ok = 1'b0;
        endcase
        imem_req_valid = req_ok & ~PCSrcE & ~reset & (credit < DEPTH_C);
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid & imem_req_ready;
    end

    // FSM and PC: redirect wins, otherwise track the single outstanding request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (PCSrcE) begin
            fetch_pc <= PCTargetE & 32'hFFFF_FFFC;
            if ((state != RUN) && !imem_rsp_valid)
                state <= DRAIN;
            else
                state <= RUN;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
            state    <= WAIT;
        end else begin
            unique case (state)
                RUN:     state <= RUN;
                WAIT:    if (imem_rsp_valid) state <= RUN;
                DRAIN:   if (imem_rsp_valid) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Decode-facing outputs: FIFO head or a NOP bubble
    always_comb begin
        fetch_valid = ~empty;
        InstrF      = empty ? NOP_INSTR : head.instr;
        PCF         = empty ? 32'h0 : head.pc;
        PCPlus4F    = PCF + 32'd4;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: vector table, directed
// corner sequences and randomized traffic against a queue model.
import fetch_pkg::*;

module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pcsrc;
    logic [31:0] target;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] rsp_data2;
    logic        rv, rv2, fv, fv2;
    logic [31:0] addr, addr2, instr, instr2, pcf, pcf2, pc4, pc42;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .PCSrcE         (pcsrc),
        .PCTargetE      (target),
        .imem_req_valid (rv),
        .imem_req_ready (ready),
        .imem_req_addr  (addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .fetch_valid    (fv),
        .InstrF         (instr),
        .PCF            (pcf),
        .PCPlus4F       (pc4)
    );

    if_fetch_stage #(
        .RESET_PC (RPC2)
    ) dut2 (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .PCSrcE         (pcsrc),
        .PCTargetE      (target),
        .imem_req_valid (rv2),
        .imem_req_ready (ready),
        .imem_req_addr  (addr2),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data2),
        .fetch_valid    (fv2),
        .InstrF         (instr2),
        .PCF            (pcf2),
        .PCPlus4F       (pc42)
    );

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    // memory environment
    bit          mem_busy = 0;
    int          mem_due = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_addr2 = '0;
    int          lat = 1;
    bit          lat_rand = 0;

    // reference model: queue of buffered PCs, instr derived from PC
    logic [31:0] mq[$];
    bit          m_out;
    bit          m_sq;
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;

    // sampled DUT values of the last cycle
    logic        s_rv, s_fv, s_rspv;
    logic [31:0] s_addr, s_pcf, s_pcf2, s_pc42;

    typedef struct {
        logic        en;
        logic        fv;
        logic [31:0] pcf;
        logic [31:0] addr;
        logic [31:0] pcf2;
        logic [31:0] pc42;
    } vec_t;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h8000_0001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        pcsrc = 1'b0;
        target = '0;
        ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        rsp_data2 = '0;
        mem_busy = 0;
        mq.delete();
        m_out = 0;
        m_sq = 0;
        m_pc = 32'h0;
        m_req_pc = 32'h0;
        #1;
        chk("rst_fetch_valid", 32'(fv), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_pcplus4", pc4, 32'h4);
        chk("rst_req_valid", 32'(rv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_cycle(input logic e, input logic rd,
                            input logic [31:0] tgt, input logic rdy);
        logic        m_fv, pop, push, e_rv;
        logic [31:0] e_pc;
        int          cnt;
        @(negedge clk);
        en = e;
        pcsrc = rd;
        target = tgt;
        ready = rdy;
        rsp_valid = mem_busy && (cyc >= mem_due);
        rsp_data = imem(mem_addr);
        rsp_data2 = imem(mem_addr2);
        #1;
        s_rv = rv;
        s_fv = fv;
        s_rspv = rsp_valid;
        s_addr = addr;
        s_pcf = pcf;
        s_pcf2 = pcf2;
        s_pc42 = pc42;

        m_fv = (mq.size() > 0);
        e_pc = m_fv ? mq[0] : 32'h0;
        pop  = e & m_fv & ~rd;
        push = rsp_valid & m_out & ~m_sq & ~rd;
        cnt  = mq.size() - int'(pop) + int'(push);
        e_rv = ~rd & ~(m_out & m_sq) & (~m_out | rsp_valid) & (cnt < 2);

        chk("fetch_valid", 32'(fv), 32'(m_fv));
        chk("instr", instr, m_fv ? imem(e_pc) : NOP);
        chk("pcf", pcf, e_pc);
        chk("pcplus4", pc4, e_pc + 32'd4);
        chk("req_valid", 32'(rv), 32'(e_rv));
        if (e_rv)
            chk("req_addr", addr, m_pc);

        if (rd) begin
            mq.delete();
            m_pc = tgt & ~32'h3;
            m_sq = m_out & ~rsp_valid;
            m_out = m_sq;
        end else begin
            if (pop)
                void'(mq.pop_front());
            if (push)
                mq.push_back(m_req_pc);
            if (rsp_valid) begin
                m_out = 0;
                m_sq = 0;
            end
            if (e_rv && rdy) begin
                m_out = 1;
                m_sq = 0;
                m_req_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end

        if (rsp_valid)
            mem_busy = 0;
        if (rv && rdy) begin
            mem_busy = 1;
            mem_addr = addr;
            mem_addr2 = addr2;
            mem_due = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[6];
        bit   seen_rv, seen_fv, hit;

        tv[0] = '{1'b1, 1'b0, 32'h0,  32'h00, 32'h0,        32'h4};
        tv[1] = '{1'b1, 1'b0, 32'h0,  32'h04, 32'h0,        32'h4};
        tv[2] = '{1'b1, 1'b1, 32'h0,  32'h08, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        tv[3] = '{1'b1, 1'b1, 32'h4,  32'h0C, 32'hFFFF_FFFC, 32'h0};
        tv[4] = '{1'b1, 1'b1, 32'h8,  32'h10, 32'h0,        32'h4};
        tv[5] = '{1'b1, 1'b1, 32'hC,  32'h14, 32'h4,        32'h8};

        // streaming with 1-cycle memory, plus wrap on the second instance
        lat = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_cycle(tv[i].en, 1'b0, 32'h0, 1'b1);
            chk("t1_fv", 32'(s_fv), 32'(tv[i].fv));
            chk("t1_pcf", s_pcf, tv[i].pcf);
            chk("t1_req_addr", s_addr, tv[i].addr);
            chk("t1_req_valid", 32'(s_rv), 32'd1);
            chk("t5_pcf_wrap", s_pcf2, tv[i].pcf2);
            chk("t5_pcplus4_wrap", s_pc42, tv[i].pc42);
        end

        // stall for 5 cycles then resume
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t2_stall_req_valid", 32'(s_rv), 32'd0);
        chk("t2_stall_fv", 32'(s_fv), 32'd1);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // redirect while a slow response is outstanding
        lat = 3;
        do_reset();
        do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b1, 32'h100, 1'b1);
        seen_rv = 0;
        seen_fv = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
            if (s_rv && !seen_rv) begin
                chk("t3_first_req_addr", s_addr, 32'h100);
                seen_rv = 1;
            end
            if (s_fv && !seen_fv) begin
                chk("t3_first_pcf", s_pcf, 32'h100);
                seen_fv = 1;
            end
        end
        chk("t3_seen_req_and_fetch", 32'({seen_rv, seen_fv}), 32'd3);

        // redirect coinciding with a response and en=0
        lat = 2;
        do_reset();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mem_busy && cyc >= mem_due && mq.size() > 0) begin
                do_cycle(1'b0, 1'b1, 32'h202, 1'b1);
                chk("t4_rsp_in_redirect", 32'(s_rspv), 32'd1);
                hit = 1;
            end else begin
                do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        chk("t4_redirect_hit", 32'(hit), 32'd1);
        do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_fifo_flushed", 32'(s_fv), 32'd0);
        seen_fv = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
            if (s_fv && !seen_fv) begin
                chk("t4_first_pcf", s_pcf, 32'h200);
                seen_fv = 1;
            end
        end
        chk("t4_seen_fetch", 32'(seen_fv), 32'd1);

        // reset while a request is outstanding
        lat = 3;
        do_reset();
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_pre_reset_fv", 32'(s_fv), 32'd1);
        do_reset();
        do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_first_req_valid", 32'(s_rv), 32'd1);
        chk("t6_first_req_addr", s_addr, 32'h0);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // randomized traffic
        lat_rand = 1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        e, rd, rdy;
            logic [31:0] t;
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            t   = $urandom;
            do_cycle(e, rd, t, rdy);
            if (i == 300) begin
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
